// File: rtl/nn_fixed_pkg.sv
// Q8.24 fixed-point constants shared by the neural-network datapath blocks.
// Covers the sigmoid PWL segment offsets and breakpoints, plus the default data width.
package nn_fixed_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [31:0] Q_ONE     = 32'h0100_0000;
  localparam logic [31:0] Q_HALF    = 32'h0080_0000;
  localparam logic [31:0] Q_0P625   = 32'h00A0_0000;
  localparam logic [31:0] Q_0P84375 = 32'h00D8_0000;

  localparam logic [31:0] TH_1P0    = 32'h0100_0000;
  localparam logic [31:0] TH_2P375  = 32'h0260_0000;
  localparam logic [31:0] TH_5P0    = 32'h0500_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves past each winner.
// The grant is only issued while the enable is high.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_enable,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_idx,
  output logic            o_grant_valid
);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_idx;
  logic           w_found;

  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(r_ptr) + k) % NREQ;
      if (!w_found && i_req[j]) begin
        w_found = 1'b1;
        w_idx   = IDW'(j);
      end
    end
  end

  assign o_grant_valid = w_found & i_enable;
  assign o_grant_idx   = w_idx;

  always_comb begin
    o_grant = '0;
    if (o_grant_valid) begin
      o_grant[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_grant_valid) begin
      r_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sigmoid.sv
// Combinational piecewise-linear sigmoid, Q8.24 signed in and out.
// Negative inputs use the symmetry 1 - f(|x|).
module sigmoid
  import nn_fixed_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] w_abs;
  logic [WIDTH-1:0] w_f;

  // The most negative input wraps to itself; unsigned compare then saturates it to 1.0.
  assign w_abs = x[WIDTH-1] ? (~x + 1'b1) : x;

  always_comb begin
    w_f = Q_ONE;
    if (w_abs < TH_1P0) begin
      w_f = ($signed(w_abs) >>> 2) + Q_HALF;
    end else if (w_abs < TH_2P375) begin
      w_f = ($signed(w_abs) >>> 3) + Q_0P625;
    end else if (w_abs < TH_5P0) begin
      w_f = ($signed(w_abs) >>> 5) + Q_0P84375;
    end
  end

  assign y = x[WIDTH-1] ? (Q_ONE - w_f) : w_f;

endmodule

// File: rtl/sigmoid_share_ctrl.sv
// Shares one sigmoid unit between NREQ requesters through a 2-stage pipeline with backpressure.
// Each result is tagged with the index of the requester that supplied the operand.
module sigmoid_share_ctrl
  import nn_fixed_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_y,
  output logic [IDW-1:0]    out_id,
  output logic              busy,
  output logic [15:0]       done_cnt
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_x;
  logic [IDW-1:0]   r_s1_id;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_y;
  logic [IDW-1:0]   r_out_id;
  logic [15:0]      r_done_cnt;

  logic             w_adv_out;
  logic             w_adv_s1;
  logic             w_accept;
  logic [IDW-1:0]   w_gidx;
  logic [WIDTH-1:0] w_y;

  assign w_adv_out = !r_out_valid | out_ready;
  assign w_adv_s1  = !r_s1_valid | w_adv_out;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (w_adv_s1 & !flush & rst_n),
    .i_req         (req_valid),
    .o_grant       (req_ready),
    .o_grant_idx   (w_gidx),
    .o_grant_valid (w_accept)
  );

  sigmoid #(
    .WIDTH (WIDTH)
  ) u_sig (
    .x (r_s1_x),
    .y (w_y)
  );

  // Flush only drops the valids; payload registers keep stale data on purpose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_x      <= '0;
      r_s1_id     <= '0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_id    <= '0;
      r_done_cnt  <= '0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_done_cnt <= r_done_cnt + 1'b1;
      end
      if (flush) begin
        r_s1_valid  <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        if (w_adv_out) begin
          r_out_y     <= w_y;
          r_out_id    <= r_s1_id;
          r_out_valid <= r_s1_valid;
        end
        if (w_adv_s1) begin
          r_s1_valid <= w_accept;
        end
        if (w_accept) begin
          r_s1_x  <= req_data[w_gidx*WIDTH +: WIDTH];
          r_s1_id <= w_gidx;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_id    = r_out_id;
  assign done_cnt  = r_done_cnt;
  assign busy      = r_s1_valid | r_out_valid;

endmodule

// File: tb/tb_sigmoid_share_ctrl.sv
// Directed bench for sigmoid_share_ctrl: PWL values, round-robin order, stall, flush and reset.
// Inputs change 1 ns after the rising edge and are checked 1 ns later.
module tb_sigmoid_share_ctrl;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_y;
  logic [IDW-1:0]        out_id;
  logic                  busy;
  logic [15:0]           done_cnt;

  int checkCount;
  int errorCount;

  logic [31:0] laneX [4] = '{32'h0000_0000, 32'h0080_0000, 32'h0100_0000, 32'hFF00_0000};
  logic [31:0] laneY [4] = '{32'h0080_0000, 32'h00A0_0000, 32'h00C0_0000, 32'h0040_0000};
  logic [31:0] singleX [7] = '{32'h0000_0000, 32'h0080_0000, 32'h0100_0000, 32'hFF00_0000,
                               32'h0300_0000, 32'h0600_0000, 32'hFA00_0000};
  logic [31:0] singleY [7] = '{32'h0080_0000, 32'h00A0_0000, 32'h00C0_0000, 32'h0040_0000,
                               32'h00F0_0000, 32'h0100_0000, 32'h0000_0000};

  sigmoid_share_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic rdy, input logic fl);
    req_valid = valid;
    out_ready = rdy;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadLanes();
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = laneX[i];
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done_cnt), 32'h0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    req_valid  = '0;
    loadLanes();
    #2;
    checkOutput("rst_y", out_y, 32'h0);
    checkOutput("rst_id", 32'(out_id), 32'h0);
    doReset();

    // Single operands from requester 0: accept, one cycle in stage 1, then visible.
    for (int v = 0; v < 7; v++) begin
      req_data[0 +: WIDTH] = singleX[v];
      applyStimulus(4'b0001, 1'b1, 1'b0);
      checkOutput($sformatf("single%0d_ready", v), 32'(req_ready), 32'h1);
      tick();
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput($sformatf("single%0d_s1", v), 32'(out_valid), 32'h0);
      checkOutput($sformatf("single%0d_busy", v), 32'(busy), 32'h1);
      tick();
      checkOutput($sformatf("single%0d_valid", v), 32'(out_valid), 32'h1);
      checkOutput($sformatf("single%0d_y", v), out_y, singleY[v]);
      checkOutput($sformatf("single%0d_id", v), 32'(out_id), 32'h0);
    end
    tick();
    checkOutput("single_done", 32'(done_cnt), 32'd7);
    checkOutput("single_idle", 32'(out_valid), 32'h0);
    loadLanes();

    // Fairness: all requesters pending, grants rotate 0,1,2,3.
    doReset();
    for (int t = 0; t < 10; t++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      checkOutput($sformatf("fair%0d_ready", t), 32'(req_ready), 32'(1 << (t % 4)));
      if (t >= 2) begin
        checkOutput($sformatf("fair%0d_id", t), 32'(out_id), 32'((t - 2) % 4));
        checkOutput($sformatf("fair%0d_y", t), out_y, laneY[(t - 2) % 4]);
      end
      tick();
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("fair_done8", 32'(done_cnt), 32'd8);
    tick();
    tick();
    checkOutput("fair_done10", 32'(done_cnt), 32'd10);
    checkOutput("fair_busy", 32'(busy), 32'h0);

    // Backpressure: pointer is at 2; two accepts, then frozen for three cycles.
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("bp0_ready", 32'(req_ready), 32'h4);
    tick();
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("bp1_ready", 32'(req_ready), 32'h8);
    tick();
    for (int t = 2; t < 5; t++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0);
      checkOutput($sformatf("bp%0d_ready", t), 32'(req_ready), 32'h0);
      checkOutput($sformatf("bp%0d_id", t), 32'(out_id), 32'h2);
      checkOutput($sformatf("bp%0d_y", t), out_y, laneY[2]);
      tick();
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("bp_rel_id", 32'(out_id), 32'h2);
    tick();
    checkOutput("bp_drain_valid", 32'(out_valid), 32'h1);
    checkOutput("bp_drain_id", 32'(out_id), 32'h3);
    checkOutput("bp_drain_y", out_y, laneY[3]);
    tick();
    checkOutput("bp_empty", 32'(out_valid), 32'h0);
    checkOutput("bp_done", 32'(done_cnt), 32'd12);

    // Pointer wrap: pointer is at 0 here.
    applyStimulus(4'b1000, 1'b1, 1'b0);
    checkOutput("wrap_g3", 32'(req_ready), 32'h8);
    tick();
    applyStimulus(4'b1001, 1'b1, 1'b0);
    checkOutput("wrap_ptr0", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(4'b1011, 1'b1, 1'b0);
    checkOutput("wrap_ptr1", 32'(req_ready), 32'h2);
    tick();
    applyStimulus(4'b1010, 1'b1, 1'b0);
    checkOutput("wrap_ptr2", 32'(req_ready), 32'h8);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("wrap_done", 32'(done_cnt), 32'd16);

    // Flush with both stages full and the output being accepted in the flush cycle.
    applyStimulus(4'b0001, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("fl_fill_ready", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(4'b0001, 1'b1, 1'b1);
    checkOutput("fl_ready", 32'(req_ready), 32'h0);
    checkOutput("fl_full", 32'(busy), 32'h1);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("fl_valid", 32'(out_valid), 32'h0);
    checkOutput("fl_busy", 32'(busy), 32'h0);
    checkOutput("fl_done", 32'(done_cnt), 32'd17);

    // Asynchronous reset mid-cycle with both stages full.
    applyStimulus(4'b0100, 1'b0, 1'b0);
    tick();
    applyStimulus(4'b0100, 1'b0, 1'b0);
    tick();
    checkOutput("mr_full", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_valid", 32'(out_valid), 32'h0);
    checkOutput("mr_busy", 32'(busy), 32'h0);
    checkOutput("mr_done", 32'(done_cnt), 32'h0);
    checkOutput("mr_y", out_y, 32'h0);
    checkOutput("mr_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("mr_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    checkOutput("mr_out_valid", 32'(out_valid), 32'h1);
    checkOutput("mr_out_id", 32'(out_id), 32'h0);
    checkOutput("mr_out_y", out_y, laneY[0]);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
